// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage of the rv32i pipeline. Owns the program counter,
// issues one word request at a time to instruction memory (req/ready with a
// variable-latency rvalid response), buffers the returned word until decode
// accepts it, and drops stale in-flight responses after a redirect.
//
// Ports
//   clk_in          clock, rising edge
//   rst_n           synchronous active-low reset
//   fetch_stall     decode not accepting this cycle
//   redirect_valid  control-flow change from execute
//   redirect_pc     redirect target (bits [1:0] forced to 0)
//   imem_req        request valid
//   imem_addr       word-aligned request address
//   imem_ready      memory accepts the request this cycle
//   imem_rvalid     response valid (one per accepted request)
//   imem_rdata      instruction word
//   fetch_valid     pc_f / next_pc_f / inst_f hold a real instruction
//   pc_f            address of the buffered instruction
//   next_pc_f       pc_f + 4 (mod 2^32)
//   inst_f          buffered instruction, NOP when fetch_valid = 0
// ----------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_in,
   input  logic        rst_n,
   input  logic        fetch_stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        fetch_valid,
   output logic [31:0] pc_f,
   output logic [31:0] next_pc_f,
   output logic [31:0] inst_f
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic        discard_q;
   logic [31:0] buf_pc_q;
   logic [31:0] buf_inst_q;

   logic [31:0] redirect_tgt;
   logic [31:0] pc_plus4;

   assign redirect_tgt = {redirect_pc[31:2], 2'b00};
   assign pc_plus4     = pc_q + 32'd4;

   // NOTE: reset is sampled on the clock edge only (synchronous), and every
   // state register is updated with <= so all of them see pre-edge values.
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC;
         discard_q  <= 1'b0;
         buf_pc_q   <= RESET_PC;
         buf_inst_q <= NOP;
      end else begin
         case (state_q)
            S_REQ: begin
               if (redirect_valid) begin
                  pc_q <= redirect_tgt;
                  // The old-address request was accepted anyway; its
                  // response must be thrown away when it arrives.
                  if (imem_ready) begin
                     state_q   <= S_WAIT;
                     discard_q <= 1'b1;
                  end
               end else if (imem_ready) begin
                  state_q <= S_WAIT;
               end
            end

            S_WAIT: begin
               if (redirect_valid) begin
                  pc_q <= redirect_tgt;
                  if (imem_rvalid) begin
                     state_q   <= S_REQ;
                     discard_q <= 1'b0;
                  end else begin
                     discard_q <= 1'b1;
                  end
               end else if (imem_rvalid) begin
                  if (discard_q) begin
                     discard_q <= 1'b0;
                     state_q   <= S_REQ;
                  end else begin
                     buf_pc_q   <= pc_q;
                     buf_inst_q <= imem_rdata;
                     state_q    <= S_HOLD;
                  end
               end
            end

            S_HOLD: begin
               // A redirect wins over consumption: pc is not advanced.
               if (redirect_valid) begin
                  pc_q    <= redirect_tgt;
                  state_q <= S_REQ;
               end else if (!fetch_stall) begin
                  pc_q    <= pc_plus4;
                  state_q <= S_REQ;
               end
            end

            default: state_q <= S_REQ;
         endcase
      end
   end

   // Gating with rst_n keeps the request low for the whole reset interval,
   // while the REQ state loaded by reset drives it high as soon as rst_n
   // is released.
   assign imem_req    = (state_q == S_REQ) && rst_n;
   assign imem_addr   = pc_q;
   assign fetch_valid = (state_q == S_HOLD);
   assign pc_f        = buf_pc_q;
   assign next_pc_f   = buf_pc_q + 32'd4;
   assign inst_f      = fetch_valid ? buf_inst_q : NOP;

   // A response may only arrive while a request is outstanding.
   rvalid_only_in_wait : assert property (
      @(posedge clk_in) disable iff (!rst_n)
      imem_rvalid |-> (state_q == S_WAIT)
   );

endmodule
